ir_id_entry_ctrl: RTL

//  Sequences multi-digit user-ID entry from the IR remote key pulses.

---
 rtl/ir_pkg.sv | 25 ++
 rtl/ir_timeout_timer.sv | 33 +++
 rtl/ir_id_entry_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// Shared types and helpers for the IR remote user-ID entry path.
package ir_pkg;

  localparam int KEY_W = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    CONFIRM = 2'd2,
    DELIVER = 2'd3
  } id_state_t;

  // Index of the highest set strobe bit; only meaningful when exactly one bit is high.
  function automatic logic [3:0] onehot_to_bcd(input logic [KEY_W-1:0] key);
    logic [3:0] bcd;
    bcd = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (key[i]) begin
        bcd = 4'(i);
      end
    end
    return bcd;
  endfunction

endpackage

// File: rtl/ir_timeout_timer.sv
// Inactivity down-counter: reloads on load, clears whenever run is low,
// and flags expiry during the last counted cycle.
module ir_timeout_timer #(
  parameter int LOAD = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(LOAD + 1);
  localparam logic [W-1:0] LOAD_V = W'(LOAD);
  localparam logic [W-1:0] ONE_V  = W'(1);

  logic [W-1:0] count;

  // run reflects whether the owner stays in a timed state next cycle, so the
  // count is already zero on the first cycle of an untimed state.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_V;
    end else if (count != '0) begin
      count <= count - ONE_V;
    end
  end

  assign expired = (count == ONE_V);

endmodule

// File: rtl/ir_id_entry_ctrl.sv
// Multi-digit user-ID entry sequencer driven by IR key strobes, with
// backspace, confirm/cancel, inactivity timeout and a valid/ack hand-off.
module ir_id_entry_ctrl
  import ir_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int TIMEOUT_CYC = 250_000_000
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic [KEY_W-1:0]        iKEY_DIGIT,
  input  logic                    iKEY_YES,
  input  logic                    iKEY_NO,
  input  logic                    iKEY_RST,
  input  logic                    iID_ACK,
  output logic [4*NUM_DIGITS-1:0] oID,
  output logic                    oID_VALID,
  output logic [3:0]              oDIGIT_CNT,
  output logic                    oBUSY,
  output logic                    oERR,
  output logic [1:0]              oSTATE
);

  localparam int ID_W = 4 * NUM_DIGITS;
  localparam int KV_W = KEY_W + 2;
  localparam logic [3:0]      CNT_ONE  = 4'd1;
  localparam logic [3:0]      CNT_FULL = 4'(NUM_DIGITS);
  localparam logic [KV_W-1:0] KV_ONE   = KV_W'(1);

  id_state_t       state;
  logic [KV_W-1:0] key_vec;
  logic            any_key;
  logic            multi_key;
  logic            one_key;
  logic            digit_key;
  logic            key_ok;
  logic [3:0]      digit_val;
  logic            timer_load;
  logic            timer_run;
  logic            timer_expired;

  // x & (x-1) is non-zero exactly when two or more strobes coincide.
  assign key_vec   = {iKEY_DIGIT, iKEY_YES, iKEY_NO};
  assign any_key   = |key_vec;
  assign multi_key = |(key_vec & (key_vec - KV_ONE));
  assign one_key   = any_key & ~multi_key;
  assign digit_key = one_key & (|iKEY_DIGIT);
  assign digit_val = onehot_to_bcd(iKEY_DIGIT);
  assign key_ok    = one_key & ~iKEY_RST & ~timer_expired;

  // Timer stays armed only while the FSM remains in ENTRY/CONFIRM next cycle.
  always_comb begin
    timer_load = 1'b0;
    timer_run  = 1'b0;
    case (state)
      IDLE: begin
        timer_load = key_ok & digit_key;
        timer_run  = key_ok & digit_key;
      end
      ENTRY: begin
        timer_load = key_ok;
        timer_run  = ~iKEY_RST & ~timer_expired
                   & ~(key_ok & iKEY_NO & (oDIGIT_CNT == CNT_ONE));
      end
      CONFIRM: begin
        timer_load = key_ok;
        timer_run  = ~iKEY_RST & ~timer_expired & ~(key_ok & (iKEY_YES | iKEY_NO));
      end
      default: begin
        timer_load = 1'b0;
        timer_run  = 1'b0;
      end
    endcase
  end

  ir_timeout_timer #(
    .LOAD(TIMEOUT_CYC)
  ) u_timer (
    .clk     (iCLK),
    .rst     (iRST),
    .load    (timer_load),
    .run     (timer_run),
    .expired (timer_expired)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state      <= IDLE;
      oID        <= '0;
      oDIGIT_CNT <= '0;
      oID_VALID  <= 1'b0;
      oERR       <= 1'b0;
    end else begin
      oERR <= 1'b0;
      if (iKEY_RST) begin
        state      <= IDLE;
        oID        <= '0;
        oDIGIT_CNT <= '0;
        oID_VALID  <= 1'b0;
      end else if (timer_expired) begin
        state      <= IDLE;
        oID        <= '0;
        oDIGIT_CNT <= '0;
        oID_VALID  <= 1'b0;
        oERR       <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (multi_key) begin
              oERR <= 1'b1;
            end else if (digit_key) begin
              oID        <= ID_W'(digit_val);
              oDIGIT_CNT <= CNT_ONE;
              state      <= (CNT_ONE == CNT_FULL) ? CONFIRM : ENTRY;
            end
          end
          ENTRY: begin
            if (multi_key) begin
              oERR <= 1'b1;
            end else if (digit_key) begin
              oID        <= (oID << 4) | ID_W'(digit_val);
              oDIGIT_CNT <= oDIGIT_CNT + CNT_ONE;
              if ((oDIGIT_CNT + CNT_ONE) == CNT_FULL) begin
                state <= CONFIRM;
              end
            end else if (one_key && iKEY_NO) begin
              oID        <= oID >> 4;
              oDIGIT_CNT <= oDIGIT_CNT - CNT_ONE;
              if (oDIGIT_CNT == CNT_ONE) begin
                state <= IDLE;
              end
            end else if (one_key && iKEY_YES) begin
              oERR <= 1'b1;
            end
          end
          CONFIRM: begin
            if (multi_key) begin
              oERR <= 1'b1;
            end else if (one_key && iKEY_YES) begin
              state     <= DELIVER;
              oID_VALID <= 1'b1;
            end else if (one_key && iKEY_NO) begin
              state      <= IDLE;
              oID        <= '0;
              oDIGIT_CNT <= '0;
            end
          end
          DELIVER: begin
            if (iID_ACK) begin
              state      <= IDLE;
              oID        <= '0;
              oDIGIT_CNT <= '0;
              oID_VALID  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign oBUSY  = (state != IDLE);
  assign oSTATE = state;

endmodule
